bus_transfer_controller: RTL and testbench

Sequences transfers on the shared 16-bit tri-state data bus. Requesters (I/O registers, general registers) ask for a bus slot; the controller arbitrates round-robin and drives exactly one source output enable onto the tri-state buffers. It then pulses the selected destination's load enable and acknowledges the requester. It sits beside the register file and I/O registers and owns every `bus_*_output_en` and destination load strobe in the design.

---
 rtl/bus_transfer_controller_if.sv | 25 ++
 rtl/bus_transfer_controller.sv | 125 ++++++++++++
 tb/tb_bus_transfer_controller.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/bus_transfer_controller_if.sv
// Bus-slot handshake between requesters and the bus transfer controller.
// Carries the requests, the enables driven onto the shared tri-state bus, and the acks.
interface bus_transfer_controller_if #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned N_DST = 4,
  parameter int unsigned DST_W = 2
);
  logic [N_SRC-1:0]       BC_req;
  logic [N_SRC*DST_W-1:0] BC_req_dst;
  logic [N_SRC-1:0]       BC_src_output_en;
  logic [N_DST-1:0]       BC_dst_load_en;
  logic [N_SRC-1:0]       BC_ack;
  logic                   BC_err;
  logic                   BC_busy;

  modport master (
    output BC_req, BC_req_dst,
    input  BC_src_output_en, BC_dst_load_en, BC_ack, BC_err, BC_busy
  );

  modport slave (
    input  BC_req, BC_req_dst,
    output BC_src_output_en, BC_dst_load_en, BC_ack, BC_err, BC_busy
  );
endinterface

// File: rtl/bus_transfer_controller.sv
// Round-robin sequencer for the shared 16-bit tri-state data bus: drive, load, ack.
// All outputs come straight from flops, computed from the next state.
module bus_transfer_controller #(
  parameter int unsigned N_SRC         = 4,
  parameter int unsigned N_DST         = 4,
  parameter int unsigned DST_W         = 2,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                        BC_clock,
  input  logic                        BC_reset,
  bus_transfer_controller_if.slave    bus
);
  localparam int unsigned SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, DRIVE, LOAD, ACK} state_t;

  state_t             state_q, state_d;
  logic [SRC_W-1:0]   grant_q, grant_d;
  logic [SRC_W-1:0]   rr_q, rr_d;
  logic [DST_W-1:0]   dst_q, dst_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_SRC-1:0]   src_en_q, src_en_d;
  logic [N_DST-1:0]   load_q, load_d;
  logic [N_SRC-1:0]   ack_q, ack_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;

  logic [DST_W-1:0]   req_dst [N_SRC];
  logic               found;
  int unsigned        idx;

  always_comb begin
    for (int unsigned k = 0; k < N_SRC; k++) begin
      req_dst[k] = bus.BC_req_dst[k*DST_W +: DST_W];
    end
  end

  // Next-state logic, then registered outputs derived from the next state.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    dst_d    = dst_q;
    cnt_d    = cnt_q;
    found    = 1'b0;
    idx      = 0;
    src_en_d = '0;
    load_d   = '0;
    ack_d    = '0;
    err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        for (int unsigned k = 0; k < N_SRC; k++) begin
          idx = (32'(rr_q) + k) % N_SRC;
          if (!found && bus.BC_req[SRC_W'(idx)]) begin
            found   = 1'b1;
            grant_d = SRC_W'(idx);
            dst_d   = req_dst[SRC_W'(idx)];
          end
        end
        if (found) begin
          cnt_d   = CNT_W'(SETTLE_CYCLES);
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = LOAD;
      end
      LOAD: state_d = ACK;
      ACK: begin
        rr_d    = (grant_q == SRC_W'(N_SRC - 1)) ? '0 : grant_q + SRC_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    for (int unsigned k = 0; k < N_SRC; k++) begin
      if (grant_d == SRC_W'(k)) begin
        src_en_d[k] = (state_d == DRIVE) || (state_d == LOAD);
        ack_d[k]    = (state_d == ACK);
      end
    end
    // An out-of-range destination matches no load enable.
    for (int unsigned j = 0; j < N_DST; j++) begin
      load_d[j] = (state_d == LOAD) && (32'(dst_d) == j);
    end
    err_d = (state_d == ACK) && (32'(dst_d) >= N_DST);
  end

  always_ff @(posedge BC_clock) begin
    if (!BC_reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_q     <= '0;
      dst_q    <= '0;
      cnt_q    <= '0;
      src_en_q <= '0;
      load_q   <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      dst_q    <= dst_d;
      cnt_q    <= cnt_d;
      src_en_q <= src_en_d;
      load_q   <= load_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.BC_src_output_en = src_en_q;
  assign bus.BC_dst_load_en   = load_q;
  assign bus.BC_ack           = ack_q;
  assign bus.BC_err           = err_q;
  assign bus.BC_busy          = busy_q;
endmodule

// File: tb/tb_bus_transfer_controller.sv
// Scoreboard bench for bus_transfer_controller: three instances cover the default
// configuration, a longer settle time, and a destination count below 2^DST_W.
module tb_bus_transfer_controller;
  typedef struct packed {
    logic [3:0] src;
    logic [3:0] load;
    logic [3:0] ack;
    logic       err;
    logic       busy;
  } obs_t;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  int   vectors = 0;
  int   miscompares = 0;
  int   sel = 0;
  logic [3:0] prev_src = '0;
  obs_t q[$];

  always #5 clk = ~clk;

  bus_transfer_controller_if #(.N_SRC(4), .N_DST(4), .DST_W(2)) if_a();
  bus_transfer_controller_if #(.N_SRC(4), .N_DST(4), .DST_W(2)) if_b();
  bus_transfer_controller_if #(.N_SRC(4), .N_DST(3), .DST_W(2)) if_c();

  bus_transfer_controller #(.N_SRC(4), .N_DST(4), .DST_W(2), .SETTLE_CYCLES(1)) dut_a (
    .BC_clock(clk), .BC_reset(rst_a), .bus(if_a));
  bus_transfer_controller #(.N_SRC(4), .N_DST(4), .DST_W(2), .SETTLE_CYCLES(3)) dut_b (
    .BC_clock(clk), .BC_reset(rst_b), .bus(if_b));
  bus_transfer_controller #(.N_SRC(4), .N_DST(3), .DST_W(2), .SETTLE_CYCLES(1)) dut_c (
    .BC_clock(clk), .BC_reset(rst_c), .bus(if_c));

  function automatic obs_t observe();
    obs_t o;
    o = '0;
    case (sel)
      0: begin
        o.src = if_a.BC_src_output_en; o.load = if_a.BC_dst_load_en;
        o.ack = if_a.BC_ack; o.err = if_a.BC_err; o.busy = if_a.BC_busy;
      end
      1: begin
        o.src = if_b.BC_src_output_en; o.load = if_b.BC_dst_load_en;
        o.ack = if_b.BC_ack; o.err = if_b.BC_err; o.busy = if_b.BC_busy;
      end
      default: begin
        o.src = if_c.BC_src_output_en; o.load = {1'b0, if_c.BC_dst_load_en};
        o.ack = if_c.BC_ack; o.err = if_c.BC_err; o.busy = if_c.BC_busy;
      end
    endcase
    return o;
  endfunction

  // Expected per-cycle trace of one transfer, starting the cycle after the grant edge.
  task automatic push_xfer(input int g, input int dst, input int settle, input int nd);
    obs_t r;
    for (int i = 0; i < settle; i++) begin
      r = '0; r.src = 4'(1 << g); r.busy = 1'b1; q.push_back(r);
    end
    r = '0; r.src = 4'(1 << g); r.busy = 1'b1;
    if (dst < nd) r.load = 4'(1 << dst);
    q.push_back(r);
    r = '0; r.ack = 4'(1 << g); r.err = (dst >= nd); r.busy = 1'b1; q.push_back(r);
    r = '0; q.push_back(r);
  endtask

  task automatic push_idle(input int n);
    obs_t r;
    r = '0;
    for (int i = 0; i < n; i++) q.push_back(r);
  endtask

  task automatic step(input string tag);
    obs_t o;
    obs_t e;
    @(posedge clk);
    @(negedge clk);
    o = observe();
    e = '0;
    if (q.size() > 0) e = q.pop_front();
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed src=%b load=%b ack=%b err=%b busy=%b, expected src=%b load=%b ack=%b err=%b busy=%b",
             tag, o.src, o.load, o.ack, o.err, o.busy, e.src, e.load, e.ack, e.err, e.busy);
    end
    vectors++;
    assert ($countones(o.src) <= 1 && !(prev_src != 4'b0 && o.src != 4'b0 && o.src != prev_src)) else begin
      miscompares++;
      $error("FAIL %s_bus_overlap: observed src=%b after src=%b, expected one-hot with an idle gap between sources",
             tag, o.src, prev_src);
    end
    prev_src = o.src;
    // Requesters hold their request until acked, then drop it.
    case (sel)
      0:       if_a.BC_req = if_a.BC_req & ~e.ack;
      1:       if_b.BC_req = if_b.BC_req & ~e.ack;
      default: if_c.BC_req = if_c.BC_req & ~e.ack;
    endcase
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    if_a.BC_req = '0; if_a.BC_req_dst = '0;
    if_b.BC_req = '0; if_b.BC_req_dst = '0;
    if_c.BC_req = '0; if_c.BC_req_dst = '0;

    sel = 0; push_idle(2); run(2, "reset_a");
    sel = 1; push_idle(1); step("reset_b");
    sel = 2; push_idle(1); step("reset_c");
    sel = 0; prev_src = '0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

    // Round-robin over all four requesters from rr_ptr = 0.
    if_a.BC_req_dst = {2'd0, 2'd1, 2'd2, 2'd3};
    push_xfer(0, 3, 1, 4); push_xfer(1, 2, 1, 4); push_xfer(2, 1, 1, 4); push_xfer(3, 0, 1, 4);
    if_a.BC_req = 4'b1111;
    run(16, "round_robin");

    // Single transfer, requester 0 to destination 2.
    if_a.BC_req_dst = 8'b0000_0010;
    push_xfer(0, 2, 1, 4);
    if_a.BC_req = 4'b0001;
    run(4, "single");

    // Grant 2 moves rr_ptr to 3, so 3 wins over 0, then 0.
    if_a.BC_req_dst = 8'b0001_0000;
    push_xfer(2, 1, 1, 4);
    if_a.BC_req = 4'b0100;
    run(4, "fair_setup");
    if_a.BC_req_dst = {2'd2, 2'd0, 2'd0, 2'd3};
    push_xfer(3, 2, 1, 4); push_xfer(0, 3, 1, 4);
    if_a.BC_req = 4'b1001;
    run(8, "fair_wrap");

    // Reset during LOAD abandons the transfer and returns rr_ptr to 0.
    if_a.BC_req_dst = 8'b0001_0000;
    push_xfer(2, 1, 1, 4);
    if_a.BC_req = 4'b0100;
    run(2, "reset_mid");
    q.delete();
    rst_a = 1'b0; if_a.BC_req = '0;
    push_idle(1); step("reset_mid_hold");
    rst_a = 1'b1;
    push_idle(1); step("reset_mid_idle");
    if_a.BC_req_dst = {2'd0, 2'd0, 2'd0, 2'd3};
    push_xfer(0, 3, 1, 4); push_xfer(3, 0, 1, 4);
    if_a.BC_req = 4'b1001;
    run(8, "post_reset");

    // Longer settle time.
    sel = 1; prev_src = '0;
    if_b.BC_req_dst = 8'b0000_0001;
    push_xfer(0, 1, 3, 4);
    if_b.BC_req = 4'b0001;
    run(6, "settle3");

    // Out-of-range destination, then a valid one on the same instance.
    sel = 2; prev_src = '0;
    if_c.BC_req_dst = 8'b0000_1100;
    push_xfer(1, 3, 1, 3);
    if_c.BC_req = 4'b0010;
    run(4, "bad_dst");
    if_c.BC_req_dst = 8'b0000_1110;
    push_xfer(0, 2, 1, 3);
    if_c.BC_req = 4'b0001;
    run(4, "dst_c_valid");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
